// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sequencer
// Purpose  : Decodes UART command bytes to start/stop streaming or to load
//            N_REGS threshold registers MSB-first, with per-byte timeout,
//            error, overrun and configuration-done reporting.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_sequencer #(
    parameter int unsigned N_REGS         = 2,
    parameter int unsigned BYTES_PER_REG  = 2,
    parameter logic [7:0]  CODE_SEND      = 8'h00,
    parameter logic [7:0]  CODE_REG       = 8'h01,
    parameter logic [7:0]  CODE_STOP      = 8'h02,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned c_byte_w      = (BYTES_PER_REG > 1) ? $clog2(BYTES_PER_REG) : 1,
    localparam int unsigned c_reg_w       = (N_REGS > 1) ? $clog2(N_REGS) : 1,
    localparam int unsigned c_tmr_w       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic                en_send,
    output logic                en_stop,
    output logic [N_REGS-1:0]   reg_wr_en,
    output logic [c_byte_w-1:0] reg_wr_byte,
    output logic [7:0]          reg_wr_data,
    output logic                cfg_done,
    output logic                cmd_error,
    output logic                rx_overrun,
    output logic                busy
);

    localparam logic [c_byte_w-1:0] c_byte_msb = c_byte_w'(BYTES_PER_REG - 1);
    localparam logic [c_reg_w-1:0]  c_reg_last = c_reg_w'(N_REGS - 1);
    localparam logic [N_REGS-1:0]   c_wen_base = N_REGS'(1);
    localparam bit                  c_tmo_en   = (TIMEOUT_CYCLES != 0);
    localparam logic [c_tmr_w-1:0]  c_tmo_last = c_tmr_w'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_SEND   = 3'd2,
        S_STOP   = 3'd3,
        S_WAIT   = 3'd4,
        S_STORE  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t              r_state;
    logic [7:0]          r_cmd;
    logic [c_reg_w-1:0]  r_reg_idx;
    logic [c_byte_w-1:0] r_byte_idx;
    logic [c_tmr_w-1:0]  r_timer;

    // All outputs are set on the edge that enters their state, so each one
    // is high for exactly the cycle the FSM spends in that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= 8'h00;
            r_reg_idx   <= '0;
            r_byte_idx  <= c_byte_msb;
            r_timer     <= '0;
            en_send     <= 1'b0;
            en_stop     <= 1'b0;
            reg_wr_en   <= '0;
            reg_wr_byte <= '0;
            reg_wr_data <= 8'h00;
            cfg_done    <= 1'b0;
            cmd_error   <= 1'b0;
            rx_overrun  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            en_send     <= 1'b0;
            en_stop     <= 1'b0;
            reg_wr_en   <= '0;
            reg_wr_byte <= '0;
            reg_wr_data <= 8'h00;
            cfg_done    <= 1'b0;
            cmd_error   <= 1'b0;
            // Only IDLE and WAIT consume bytes; anywhere else the byte is lost.
            rx_overrun  <= rx_ready && (r_state != S_IDLE) && (r_state != S_WAIT);

            case (r_state)
                S_IDLE: begin
                    if (rx_ready) begin
                        r_cmd   <= rx_data;
                        r_state <= S_DECODE;
                        busy    <= 1'b1;
                    end else begin
                        busy    <= 1'b0;
                    end
                end

                S_DECODE: begin
                    busy <= 1'b1;
                    if (r_cmd == CODE_SEND) begin
                        r_state <= S_SEND;
                        en_send <= 1'b1;
                    end else if (r_cmd == CODE_STOP) begin
                        r_state <= S_STOP;
                        en_stop <= 1'b1;
                    end else if (r_cmd == CODE_REG) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end else begin
                        r_state   <= S_ERR;
                        cmd_error <= 1'b1;
                    end
                end

                S_SEND, S_STOP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end

                S_WAIT: begin
                    busy <= 1'b1;
                    if (rx_ready) begin
                        r_state     <= S_STORE;
                        reg_wr_en   <= c_wen_base << r_reg_idx;
                        reg_wr_byte <= r_byte_idx;
                        reg_wr_data <= rx_data;
                    end else if (c_tmo_en && (r_timer == c_tmo_last)) begin
                        r_state   <= S_ERR;
                        cmd_error <= 1'b1;
                    end else if (c_tmo_en) begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end

                S_STORE: begin
                    busy    <= 1'b1;
                    r_timer <= '0;
                    if (r_byte_idx == '0) begin
                        if (r_reg_idx == c_reg_last) begin
                            r_state  <= S_DONE;
                            cfg_done <= 1'b1;
                        end else begin
                            r_reg_idx  <= r_reg_idx + c_reg_w'(1);
                            r_byte_idx <= c_byte_msb;
                            r_state    <= S_WAIT;
                        end
                    end else begin
                        r_byte_idx <= r_byte_idx - c_byte_w'(1);
                        r_state    <= S_WAIT;
                    end
                end

                S_DONE: begin
                    r_state    <= S_IDLE;
                    busy       <= 1'b0;
                    r_reg_idx  <= '0;
                    r_byte_idx <= c_byte_msb;
                end

                S_ERR: begin
                    r_state    <= S_IDLE;
                    busy       <= 1'b0;
                    r_reg_idx  <= '0;
                    r_byte_idx <= c_byte_msb;
                    r_timer    <= '0;
                end

                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_sequencer
// Purpose  : Directed self-checking bench for uart_cmd_sequencer
//            (N_REGS=2, BYTES_PER_REG=2, TIMEOUT_CYCLES=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       en_send;
    logic       en_stop;
    logic [1:0] reg_wr_en;
    logic [0:0] reg_wr_byte;
    logic [7:0] reg_wr_data;
    logic       cfg_done;
    logic       cmd_error;
    logic       rx_overrun;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    uart_cmd_sequencer #(
        .N_REGS         (2),
        .BYTES_PER_REG  (2),
        .CODE_SEND      (8'h00),
        .CODE_REG       (8'h01),
        .CODE_STOP      (8'h02),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .en_send     (en_send),
        .en_stop     (en_stop),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_byte (reg_wr_byte),
        .reg_wr_data (reg_wr_data),
        .cfg_done    (cfg_done),
        .cmd_error   (cmd_error),
        .rx_overrun  (rx_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    logic [16:0] w_obs;
    assign w_obs = {en_send, en_stop, reg_wr_en, reg_wr_byte, reg_wr_data,
                    cfg_done, cmd_error, rx_overrun, busy};

    function automatic logic [16:0] pk(input logic s, input logic p, input logic [1:0] w,
                                       input logic b, input logic [7:0] d, input logic dn,
                                       input logic er, input logic ov, input logic bz);
        return {s, p, w, b, d, dn, er, ov, bz};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [16:0] exp);
        checks++;
        assert (w_obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%05h expected=%05h", tag, w_obs, exp);
        end
    endtask

    // Strobe one byte for one cycle; returns one cycle after the strobe.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    localparam logic [16:0] c_idle = 17'h0;
    localparam logic [16:0] c_busy = 17'h1;

    initial begin
        reset    = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        repeat (3) tick();
        check("reset_state", c_idle);
        reset = 1'b0;
        tick();
        check("idle_after_reset", c_idle);

        // Start streaming
        send_byte(8'h00);
        check("send_decode", c_busy);
        tick();
        check("send_pulse", pk(1, 0, 2'b00, 0, 8'h00, 0, 0, 0, 1));
        tick();
        check("send_back_idle", c_idle);

        // Full register load with 5-cycle byte spacing
        send_byte(8'h01);
        check("reg_decode", c_busy);
        tick();
        check("reg_wait0", c_busy);
        repeat (4) tick();
        send_byte(8'h12);
        check("wr_r0_b1", pk(0, 0, 2'b01, 1, 8'h12, 0, 0, 0, 1));
        tick();
        check("wait1", c_busy);
        repeat (3) tick();
        send_byte(8'h34);
        check("wr_r0_b0", pk(0, 0, 2'b01, 0, 8'h34, 0, 0, 0, 1));
        tick();
        repeat (3) tick();
        send_byte(8'h56);
        check("wr_r1_b1", pk(0, 0, 2'b10, 1, 8'h56, 0, 0, 0, 1));
        tick();
        repeat (3) tick();
        send_byte(8'h78);
        check("wr_r1_b0", pk(0, 0, 2'b10, 0, 8'h78, 0, 0, 0, 1));
        tick();
        check("cfg_done", pk(0, 0, 2'b00, 0, 8'h00, 1, 0, 0, 1));
        tick();
        check("cfg_back_idle", c_idle);

        // Unknown command, then stop
        send_byte(8'h7F);
        check("bad_decode", c_busy);
        tick();
        check("bad_cmd_error", pk(0, 0, 2'b00, 0, 8'h00, 0, 1, 0, 1));
        tick();
        check("bad_back_idle", c_idle);
        send_byte(8'h02);
        tick();
        check("stop_pulse", pk(0, 1, 2'b00, 0, 8'h00, 0, 0, 0, 1));
        tick();
        check("stop_back_idle", c_idle);

        // Timeout: one byte, then silence
        send_byte(8'h01);
        tick();
        send_byte(8'hAA);
        check("tmo_write", pk(0, 0, 2'b01, 1, 8'hAA, 0, 0, 0, 1));
        tick();
        check("tmo_wait_entry", c_busy);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check($sformatf("tmo_still_wait_%0d", k), c_busy);
        end
        tick();
        check("tmo_cmd_error", pk(0, 0, 2'b00, 0, 8'h00, 0, 1, 0, 1));
        tick();
        check("tmo_back_idle", c_idle);

        // Byte arriving on the last allowed cycle wins over the timeout
        send_byte(8'h01);
        tick();
        repeat (15) tick();
        send_byte(8'hBB);
        check("tmo_edge_write", pk(0, 0, 2'b01, 1, 8'hBB, 0, 0, 0, 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("tmo_edge_reset", c_idle);

        // Reset mid-configuration restarts at reg0 MSB
        send_byte(8'h01);
        tick();
        send_byte(8'h11);
        tick();
        send_byte(8'h22);
        check("rst_pre_write", pk(0, 0, 2'b01, 0, 8'h22, 0, 0, 0, 1));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_idle", c_idle);
        send_byte(8'h01);
        tick();
        send_byte(8'h33);
        check("rst_restart_r0_b1", pk(0, 0, 2'b01, 1, 8'h33, 0, 0, 0, 1));
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Overrun while decoding; the dropped byte must not be executed
        send_byte(8'h00);
        check("ovr_decode", c_busy);
        send_byte(8'h02);
        check("ovr_send_pulse", pk(1, 0, 2'b00, 0, 8'h00, 0, 0, 1, 1));
        tick();
        check("ovr_back_idle", c_idle);
        tick();
        check("ovr_dropped", c_idle);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
